// File: rtl/e1_rx_bd_ctrl.sv
// E1 RX buffer-descriptor controller: submit queue, one active descriptor to the
// RX block, completion queue back to the host, miss counter, overflow flag and flush.
module e1_rx_bd_ctrl #(
    parameter int MFW = 7,
    parameter int QL2 = 2,
    parameter int MCW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [MFW-1:0] sub_mf,
    input  logic           sub_valid,
    output logic           sub_ready,
    output logic [MFW-1:0] cpl_mf,
    output logic [1:0]     cpl_crc_e,
    output logic           cpl_abort,
    output logic           cpl_valid,
    input  logic           cpl_ready,
    output logic [MFW-1:0] bd_mf,
    output logic           bd_valid,
    input  logic [1:0]     bd_crc_e,
    input  logic           bd_done,
    input  logic           bd_miss,
    input  logic           ctl_flush,
    output logic [MCW-1:0] stat_miss_cnt,
    input  logic           stat_miss_clr,
    output logic           stat_ovfl,
    input  logic           stat_ovfl_clr,
    output logic           stat_idle
);

    localparam int DEPTH = 1 << QL2;
    localparam int CW    = MFW + 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [MFW-1:0] r_bd_mf;

    logic [MFW-1:0] r_sq_mem [DEPTH];
    logic [QL2:0]   r_sq_wp;
    logic [QL2:0]   r_sq_rp;
    logic [QL2:0]   w_sq_cnt;
    logic           w_sq_empty;
    logic           w_sq_full;
    logic           w_sq_push;
    logic           w_sq_pop;
    logic [MFW-1:0] w_sq_head;
    logic           w_load;

    logic [CW-1:0]  r_cq_mem [DEPTH];
    logic [QL2:0]   r_cq_wp;
    logic [QL2:0]   r_cq_rp;
    logic [QL2:0]   w_cq_cnt;
    logic           w_cq_empty;
    logic           w_cq_full;
    logic           w_cq_push;
    logic           w_cq_pop;
    logic           w_cq_drop;
    logic           w_cq_wr;
    logic [CW-1:0]  w_cq_din;
    logic [CW-1:0]  w_cq_head;

    logic [MCW-1:0] r_miss_cnt;
    logic           r_ovfl;

    assign w_sq_cnt   = r_sq_wp - r_sq_rp;
    assign w_sq_empty = (w_sq_cnt == (QL2+1)'(0));
    assign w_sq_full  = (w_sq_cnt == (QL2+1)'(DEPTH));
    assign w_sq_head  = r_sq_mem[r_sq_rp[QL2-1:0]];
    assign sub_ready  = ~w_sq_full & ~ctl_flush & (r_state != ST_FLUSH);
    assign w_sq_push  = sub_valid & sub_ready;

    assign w_cq_cnt   = r_cq_wp - r_cq_rp;
    assign w_cq_empty = (w_cq_cnt == (QL2+1)'(0));
    assign w_cq_full  = (w_cq_cnt == (QL2+1)'(DEPTH));
    assign w_cq_head  = r_cq_mem[r_cq_rp[QL2-1:0]];
    assign w_cq_pop   = ~w_cq_empty & cpl_ready;
    // A full queue only drops when the host is not popping in the same cycle.
    assign w_cq_drop  = w_cq_push & w_cq_full & ~w_cq_pop;
    assign w_cq_wr    = w_cq_push & ~w_cq_drop;

    assign cpl_valid  = ~w_cq_empty;
    assign {cpl_mf, cpl_crc_e, cpl_abort} = w_cq_empty ? {CW{1'b0}} : w_cq_head;

    assign bd_mf         = r_bd_mf;
    assign bd_valid      = (r_state == ST_ACTIVE);
    assign stat_idle     = ~bd_valid & w_sq_empty;
    assign stat_miss_cnt = r_miss_cnt;
    assign stat_ovfl     = r_ovfl;

    // Next-state, queue pops and completion generation.
    always_comb begin
        w_state_nxt = r_state;
        w_sq_pop    = 1'b0;
        w_load      = 1'b0;
        w_cq_push   = 1'b0;
        w_cq_din    = {CW{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (ctl_flush) begin
                    w_state_nxt = w_sq_empty ? ST_IDLE : ST_FLUSH;
                end else if (bd_miss && !w_sq_empty) begin
                    w_sq_pop    = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ctl_flush) begin
                    // A coincident bd_done means the MF was fully written: report it normally.
                    w_cq_push   = 1'b1;
                    w_cq_din    = {r_bd_mf, (bd_done ? bd_crc_e : 2'b00), ~bd_done};
                    w_state_nxt = w_sq_empty ? ST_IDLE : ST_FLUSH;
                end else if (bd_done) begin
                    w_cq_push = 1'b1;
                    w_cq_din  = {r_bd_mf, bd_crc_e, 1'b0};
                    if (!w_sq_empty) begin
                        w_sq_pop    = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_FLUSH: begin
                // Submits are blocked here, so a count of one means this is the last entry.
                if (!w_sq_empty) begin
                    w_sq_pop    = 1'b1;
                    w_cq_push   = 1'b1;
                    w_cq_din    = {w_sq_head, 2'b00, 1'b1};
                    w_state_nxt = (w_sq_cnt == (QL2+1)'(1)) ? ST_IDLE : ST_FLUSH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and active descriptor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bd_mf <= {MFW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_bd_mf <= w_sq_head;
            end
        end
    end

    // Submit queue storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq_wp <= (QL2+1)'(0);
            r_sq_rp <= (QL2+1)'(0);
            for (int i = 0; i < DEPTH; i++) begin
                r_sq_mem[i] <= {MFW{1'b0}};
            end
        end else begin
            if (w_sq_push) begin
                r_sq_mem[r_sq_wp[QL2-1:0]] <= sub_mf;
                r_sq_wp <= r_sq_wp + (QL2+1)'(1);
            end
            if (w_sq_pop) begin
                r_sq_rp <= r_sq_rp + (QL2+1)'(1);
            end
        end
    end

    // Completion queue storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cq_wp <= (QL2+1)'(0);
            r_cq_rp <= (QL2+1)'(0);
            for (int i = 0; i < DEPTH; i++) begin
                r_cq_mem[i] <= {CW{1'b0}};
            end
        end else begin
            if (w_cq_wr) begin
                r_cq_mem[r_cq_wp[QL2-1:0]] <= w_cq_din;
                r_cq_wp <= r_cq_wp + (QL2+1)'(1);
            end
            if (w_cq_pop) begin
                r_cq_rp <= r_cq_rp + (QL2+1)'(1);
            end
        end
    end

    // Saturating miss counter; a clear with a coincident miss lands on one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_cnt <= {MCW{1'b0}};
        end else if (stat_miss_clr) begin
            r_miss_cnt <= bd_miss ? MCW'(1) : {MCW{1'b0}};
        end else if (bd_miss && (r_miss_cnt != {MCW{1'b1}})) begin
            r_miss_cnt <= r_miss_cnt + MCW'(1);
        end
    end

    // Sticky completion-overflow flag; setting beats clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovfl <= 1'b0;
        end else if (w_cq_drop) begin
            r_ovfl <= 1'b1;
        end else if (stat_ovfl_clr) begin
            r_ovfl <= 1'b0;
        end
    end

endmodule
